color_palette: RTL

- Parametrised, writable successor to the fixed block-type colour decode.
- Maps a block-type index to a packed RGB word through a register-file palette loaded with the default tetromino colours at reset.
- Two-stage registered lookup pipeline, aligned to the pixel stream.
- Built-in flash FSM that blinks highlighted cells to white during line-clear animation.
- Sits between board-cell fetch and the VGA output register.

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/color_palette_flash_ctrl.sv | 67 ++++++
 rtl/color_palette.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared constants for the colour path: default tetromino palette,
// flash FSM state encodings and a nibble-to-channel widening helper.
package tetris_pkg;

    // Default palette, {ch2,ch1,ch0} with 4-bit channels, entries 0..7.
    localparam logic [11:0] DEF_PAL [8] = '{
        12'h666, 12'hFF0, 12'h0FF, 12'hC0C,
        12'h0F0, 12'h00F, 12'hF00, 12'h07F
    };

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_ON   = 2'd1,
        FL_OFF  = 2'd2
    } flash_state_t;

    // Repeat a nibble MSB-first to fill w bits (w <= 32); result in [w-1:0].
    function automatic logic [31:0] rep_nib(input logic [3:0] nib, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[w-1-i] = nib[3-(i%4)];
        end
        return r;
    endfunction

endpackage

// File: rtl/color_palette_flash_ctrl.sv
// Flash sequencer: IDLE/ON/OFF FSM that alternates phases every
// FLASH_PERIOD frame ticks for FLASH_TOGGLES phase changes.
module flash_ctrl
    import tetris_pkg::*;
#(
    parameter int FLASH_TOGGLES = 6,
    parameter int FLASH_PERIOD  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic flash_req,
    output logic flash_on,
    output logic flash_busy
);

    localparam int TICK_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int TOG_W  = $clog2(FLASH_TOGGLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FLASH_PERIOD - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(FLASH_TOGGLES - 1);

    flash_state_t      r_state, w_nxt_state;
    logic [TICK_W-1:0] r_tick,  w_nxt_tick;
    logic [TOG_W-1:0]  r_tog,   w_nxt_tog;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FL_IDLE;
            r_tick  <= '0;
            r_tog   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_tick  <= w_nxt_tick;
            r_tog   <= w_nxt_tog;
        end
    end

    // Next state: a request always restarts, even on the terminal tick.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_tick  = r_tick;
        w_nxt_tog   = r_tog;
        if (flash_req) begin
            w_nxt_state = FL_ON;
            w_nxt_tick  = '0;
            w_nxt_tog   = '0;
        end else if (r_state != FL_IDLE && frame_tick) begin
            if (r_tick == TICK_LAST) begin
                w_nxt_tick = '0;
                if (r_tog == TOG_LAST) begin
                    w_nxt_state = FL_IDLE;
                    w_nxt_tog   = '0;
                end else begin
                    w_nxt_tog   = r_tog + 1'b1;
                    w_nxt_state = (r_state == FL_ON) ? FL_OFF : FL_ON;
                end
            end else begin
                w_nxt_tick = r_tick + 1'b1;
            end
        end
    end

    assign flash_on   = (r_state == FL_ON);
    assign flash_busy = (r_state != FL_IDLE);

endmodule

// File: rtl/color_palette.sv
// Writable block-type colour palette with a two-stage lookup pipeline and
// line-clear flash override. Optional dimming: define COLOR_PALETTE_DIM_EN.
module color_palette
    import tetris_pkg::*;
#(
    parameter int TYPE_W        = 3,
    parameter int CH_W          = 4,
    parameter int FLASH_TOGGLES = 6,
    parameter int FLASH_PERIOD  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic [TYPE_W-1:0]   blktype,
    input  logic                highlight,
    input  logic                wr_en,
    input  logic [TYPE_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                frame_tick,
    input  logic                flash_req,
    input  logic                dim,
    output logic [3*CH_W-1:0]   color,
    output logic                color_valid,
    output logic                flash_busy
);

    localparam int DEPTH = 2**TYPE_W;
    localparam int COL_W = 3*CH_W;

    logic [COL_W-1:0] w_def [DEPTH];
    logic [COL_W-1:0] r_pal [DEPTH];
    logic [COL_W-1:0] w_rd;
    logic [COL_W-1:0] r_s1_col;
    logic             r_s1_hl;
    logic             r_s1_vld;
    logic [COL_W-1:0] w_s2_col;
    logic             w_flash_on;

    // Reset image of the palette, widened to CH_W bits per channel.
    for (genvar g = 0; g < DEPTH; g++) begin : g_def
        if (g < 8) begin : g_tet
            localparam logic [31:0] R0 = rep_nib(DEF_PAL[g][3:0],  CH_W);
            localparam logic [31:0] R1 = rep_nib(DEF_PAL[g][7:4],  CH_W);
            localparam logic [31:0] R2 = rep_nib(DEF_PAL[g][11:8], CH_W);
            assign w_def[g] = {R2[CH_W-1:0], R1[CH_W-1:0], R0[CH_W-1:0]};
        end else begin : g_zero
            assign w_def[g] = '0;
        end
    end

    // Palette register file; reset reloads the defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pal[i] <= w_def[i];
        end else if (wr_en) begin
            r_pal[wr_addr] <= wr_data;
        end
    end

    // Read with write-through so a same-cycle write is seen by the lookup.
    always_comb begin
        w_rd = r_pal[blktype];
        if (wr_en && (wr_addr == blktype)) w_rd = wr_data;
    end

    // S1: capture looked-up colour and sideband bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_col <= '0;
            r_s1_hl  <= 1'b0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_col <= w_rd;
            r_s1_hl  <= highlight;
            r_s1_vld <= pix_valid;
        end
    end

`ifdef COLOR_PALETTE_DIM_EN
    logic r_s1_dim;

    // S1 dim bit travels with the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_s1_dim <= 1'b0;
        else     r_s1_dim <= dim;
    end

    // S2 colour: flash forces white, otherwise optionally halve each channel.
    always_comb begin
        w_s2_col = r_s1_col;
        if (w_flash_on && r_s1_hl) begin
            w_s2_col = '1;
        end else if (r_s1_dim) begin
            for (int c = 0; c < 3; c++)
                w_s2_col[c*CH_W +: CH_W] = r_s1_col[c*CH_W +: CH_W] >> 1;
        end
    end
`else
    logic w_dim_unused;
    assign w_dim_unused = dim;

    // S2 colour: flash forces white on highlighted cells during ON.
    always_comb begin
        w_s2_col = r_s1_col;
        if (w_flash_on && r_s1_hl) w_s2_col = '1;
    end
`endif

    // S2 register: colour only updates for valid pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color       <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= r_s1_vld;
            if (r_s1_vld) color <= w_s2_col;
        end
    end

    flash_ctrl #(
        .FLASH_TOGGLES (FLASH_TOGGLES),
        .FLASH_PERIOD  (FLASH_PERIOD)
    ) u_flash (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .flash_req  (flash_req),
        .flash_on   (w_flash_on),
        .flash_busy (flash_busy)
    );

endmodule
